ex_branch_feedback_stash: RTL and testbench
===========================================

Name: ex_branch_feedback_stash

Overview:
- Closes the prediction loop for the IF-stage GShare predictor.
- Buffers each conditional branch predicted in IF, in program order, until EX resolves it.
- On resolution, produces the registered training interface the predictor consumes: pc_jmp_feedback, pc_jmp_take, pc_stash_base.
- Detects mispredictions and issues a flush/redirect to the PC unit.

Parameters:
- DEPTH, 4, number of in-flight predicted branches; power of two.
- PTR_W, 2, log2(DEPTH); pointer width.
- PC_STEP, 32'd4, sequential PC increment used for the not-taken redirect.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- if_push  in  1  IF issued a conditional branch this cycle.
- if_push_pc  in  32  PC of that branch.
- if_push_take  in  1  predicted direction (predictor output).
- push_ready  out  1  stash not full; IF stalls branch issue when 0.
- ex_resolve  in  1  EX resolved the oldest in-flight branch this cycle.
- ex_take  in  1  actual direction.
- ex_target  in  32  actual taken target.
- pc_jmp_feedback  out  1  one-cycle training pulse to predictor.
- pc_jmp_take  out  1  actual direction, valid with feedback.
- pc_stash_base  out  32  PC of resolved branch, valid with feedback.
- pc_mispredict  out  1  one-cycle flush/redirect pulse.
- pc_redirect  out  32  correct next PC, valid with mispredict.
- stash_count  out  PTR_W+1  entries currently held.
- stash_underflow  out  1  sticky error: resolve seen while empty.

Behaviour:
- Reset (synchronous, clk edge with reset=1): rd/wr pointers=0, count=0, stash_underflow=0, all other outputs 0. Reset wins over every simultaneous event, including mid-flush.
- Storage: circular buffer of {pc[31:0], pred_take}. Pointers wrap modulo DEPTH. push_ready = (count != DEPTH), combinational from count.
- Push: if_push && push_ready writes at wr_ptr; wr_ptr++, count++. if_push while full is a protocol violation; entry dropped, state unchanged.
- Resolve (count>0): pops the entry at rd_ptr. Next edge, outputs are registered:
  - pc_jmp_feedback=1
  - pc_jmp_take=ex_take
  - pc_stash_base=entry.pc
- Latency is exactly 1 cycle from ex_resolve to feedback.
- Mispredict: when ex_take != entry.pred_take, in the same registered cycle as feedback:
  - pc_mispredict=1
  - pc_redirect = ex_take ? ex_target : entry.pc+PC_STEP (32-bit wrap)
- Flush: on the detecting edge, all younger entries are discarded (rd_ptr=wr_ptr, count=0). A simultaneous if_push is discarded (wrong path). Pushes in the following cycle, while pc_mispredict=1, are also discarded. push_ready stays high during the flush.
- Correct prediction with simultaneous push and resolve: count unchanged, both pointers advance.
- Resolve on empty: no feedback, no pop, stash_underflow set (sticky until reset).
- Pulse outputs (feedback, mispredict) are high for exactly one cycle per resolve. Data outputs hold their last value otherwise.
- No FSM beyond the flush-shadow flag: NORMAL -> FLUSH_SHADOW on mispredict detect; FLUSH_SHADOW -> NORMAL unconditionally next cycle. A resolve during FLUSH_SHADOW with count=0 counts as underflow.

Optional Feature:
- Macro: BRANCH_STASH_STATS_EN.
- When defined: adds outputs stat_resolved[31:0] and stat_mispredict[31:0].
  - Each increments on the edge that registers feedback or mispredict respectively.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: no ports, no counters, behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - stash entry typedef {pc, pred_take}
  - PC_STEP
  - the 2-bit predictor counter encodings: TAKE=01, TAKE_TAKE=11, NTAKE=00, NTAKE_NTAKE=10
- One natural sub-module: branch_stash_fifo. It is a generic DEPTH-entry circular buffer with push/pop/flush/count.
- The resolve and redirect logic stays in the top.

Test Plan:
- Reset, then push pc=0x100 pred=1; resolve take=1 target=0x200 -> next cycle: feedback=1, take=1, base=0x100, mispredict=0, count=0.
- Push pc=0x104 pred=1; resolve take=0 -> feedback=1, mispredict=1, redirect=0x108, count=0.
- Push 0x10, 0x20, 0x30 (pred=0); resolve the first with take=1 target=0x80 while pushing 0x40 -> redirect=0x80, count=0, 0x40 discarded, a push on the next cycle also discarded.
- Push 4 entries -> push_ready=0, count=4. A 5th push is ignored. Pop with 4 correct resolves -> bases return in push order, pointers wrap, push_ready=1.
- Resolve with count=0 -> no feedback, stash_underflow=1 and held. Synchronous reset clears it. Reset asserted the cycle after a mispredict clears the shadow.
- With BRANCH_STASH_STATS_EN: 3 resolves including 1 mispredict -> stat_resolved=3, stat_mispredict=1.

Source files
------------

// File: rtl/ex_branch_feedback_stash_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_branch_feedback_stash_pkg: shared types for the branch feedback stash.
// Revision: 1.0
// ----------------------------------------------------------------------------
package ex_branch_feedback_stash_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_take;
  } stash_entry_t;

  // 2-bit GShare saturating counter encodings
  typedef enum logic [1:0] {
    NTAKE       = 2'b00,
    TAKE        = 2'b01,
    NTAKE_NTAKE = 2'b10,
    TAKE_TAKE   = 2'b11
  } pred_counter_t;

  typedef enum logic [0:0] {
    ST_NORMAL       = 1'b0,
    ST_FLUSH_SHADOW = 1'b1
  } shadow_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_stash_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_stash_fifo: DEPTH-entry circular buffer with push/pop/flush/count.
// Revision: 1.0
// ----------------------------------------------------------------------------
module branch_stash_fifo
  import ex_branch_feedback_stash_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  stash_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output stash_entry_t     head,
  output logic [PTR_W:0]   count
);

  stash_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   w_wr_next;

  always_comb begin
    w_wr_next = push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    head      = r_mem[r_rd_ptr];
    count     = r_count;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      if (flush) begin
        // flush drops everything, including a same-edge push
        r_rd_ptr <= w_wr_next;
        r_count  <= '0;
      end else begin
        if (pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_branch_feedback_stash.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_branch_feedback_stash: holds IF-predicted branches until EX resolves them,
// trains the predictor and redirects on mispredict. Option: BRANCH_STASH_STATS_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ex_branch_feedback_stash
  import ex_branch_feedback_stash_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_push,
  input  logic [31:0]      if_push_pc,
  input  logic             if_push_take,
  output logic             push_ready,
  input  logic             ex_resolve,
  input  logic             ex_take,
  input  logic [31:0]      ex_target,
  output logic             pc_jmp_feedback,
  output logic             pc_jmp_take,
  output logic [31:0]      pc_stash_base,
  output logic             pc_mispredict,
  output logic [31:0]      pc_redirect,
  output logic [PTR_W:0]   stash_count,
  output logic             stash_underflow
`ifdef BRANCH_STASH_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispredict
`endif
);

  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  stash_entry_t   w_head;
  stash_entry_t   w_push_entry;
  logic [PTR_W:0] w_count;
  logic           w_resolve_ok;
  logic           w_mispredict;
  logic           w_push_ok;
  logic           w_pop;
  logic           w_empty_resolve;
  logic [31:0]    w_redirect;
  shadow_state_t  r_state;
  shadow_state_t  w_state_next;

  branch_stash_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push_ok),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .flush      (w_mispredict),
    .head       (w_head),
    .count      (w_count)
  );

  always_comb begin
    push_ready      = (w_count != C_FULL);
    stash_count     = w_count;
    w_push_entry    = '{pc: if_push_pc, pred_take: if_push_take};
    w_resolve_ok    = ex_resolve && (w_count != '0);
    w_empty_resolve = ex_resolve && (w_count == '0);
    w_mispredict    = w_resolve_ok && (ex_take != w_head.pred_take);
    w_pop           = w_resolve_ok && !w_mispredict;
    // wrong-path pushes: same edge as detection and the shadow cycle after it
    w_push_ok       = if_push && push_ready && !w_mispredict && (r_state == ST_NORMAL);
    w_redirect      = ex_take ? ex_target : w_head.pc + PC_STEP;
  end

  always_comb begin
    w_state_next = ST_NORMAL;
    if (w_mispredict) begin
      w_state_next = ST_FLUSH_SHADOW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_jmp_feedback <= 1'b0;
      pc_jmp_take     <= 1'b0;
      pc_stash_base   <= '0;
      pc_mispredict   <= 1'b0;
      pc_redirect     <= '0;
      stash_underflow <= 1'b0;
    end else begin
      pc_jmp_feedback <= w_resolve_ok;
      pc_mispredict   <= w_mispredict;
      if (w_resolve_ok) begin
        pc_jmp_take   <= ex_take;
        pc_stash_base <= w_head.pc;
      end
      if (w_mispredict) begin
        pc_redirect <= w_redirect;
      end
      if (w_empty_resolve) begin
        stash_underflow <= 1'b1;
      end
    end
  end

`ifdef BRANCH_STASH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (w_resolve_ok && (stat_resolved != '1)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (w_mispredict && (stat_mispredict != '1)) begin
        stat_mispredict <= stat_mispredict + 32'd1;
      end
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_feedback_stash.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ex_branch_feedback_stash: table vectors, directed reset sequences and
// random stimulus against a queue-based model. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ex_branch_feedback_stash;

  logic        clk = 1'b0;
  logic        reset, if_push, if_push_take, ex_resolve, ex_take;
  logic [31:0] if_push_pc, ex_target;
  logic        push_ready, pc_jmp_feedback, pc_jmp_take, pc_mispredict, stash_underflow;
  logic [31:0] pc_stash_base, pc_redirect;
  logic [2:0]  stash_count;
`ifdef BRANCH_STASH_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif

  always #5 clk = ~clk;

  ex_branch_feedback_stash #(.DEPTH(4), .PTR_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_push         (if_push),
    .if_push_pc      (if_push_pc),
    .if_push_take    (if_push_take),
    .push_ready      (push_ready),
    .ex_resolve      (ex_resolve),
    .ex_take         (ex_take),
    .ex_target       (ex_target),
    .pc_jmp_feedback (pc_jmp_feedback),
    .pc_jmp_take     (pc_jmp_take),
    .pc_stash_base   (pc_stash_base),
    .pc_mispredict   (pc_mispredict),
    .pc_redirect     (pc_redirect),
    .stash_count     (stash_count),
    .stash_underflow (stash_underflow)
`ifdef BRANCH_STASH_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispredict (stat_mispredict)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of in-flight branches in program order
  typedef struct packed { logic [31:0] pc; logic pred; } ent_t;
  ent_t        m_q[$];
  logic        m_fb, m_jt, m_mis, m_uf, m_shadow;
  logic [31:0] m_base, m_redir, m_sres, m_smis;

  task automatic model(input logic rst, push, input logic [31:0] pc, input logic pred,
                       input logic res, take, input logic [31:0] tgt);
    ent_t e;
    int   sz;
    logic mis;
    if (rst) begin
      m_q.delete();
      {m_fb, m_jt, m_mis, m_uf, m_shadow} = '0;
      m_base = 0; m_redir = 0; m_sres = 0; m_smis = 0;
      return;
    end
    sz   = m_q.size();
    mis  = 1'b0;
    m_fb = res && (sz > 0);
    if (m_fb) begin
      e      = m_q.pop_front();
      m_jt   = take;
      m_base = e.pc;
      mis    = (take != e.pred);
      if (mis) m_redir = take ? tgt : e.pc + 32'd4;
      if (m_sres != 32'hFFFF_FFFF) m_sres = m_sres + 1;
      if (mis && m_smis != 32'hFFFF_FFFF) m_smis = m_smis + 1;
    end
    m_mis = mis;
    if (res && sz == 0) m_uf = 1'b1;
    if (mis) m_q.delete();
    else if (push && sz < 4 && !m_shadow) m_q.push_back('{pc: pc, pred: pred});
    m_shadow = mis;
  endtask

  task automatic cycle(input logic rst, push, input logic [31:0] pc, input logic pred,
                       input logic res, take, input logic [31:0] tgt);
    reset = rst; if_push = push; if_push_pc = pc; if_push_take = pred;
    ex_resolve = res; ex_take = take; ex_target = tgt;
    model(rst, push, pc, pred, res, take, tgt);
    @(posedge clk);
    #1;
    chk("m_feedback", 32'(pc_jmp_feedback), 32'(m_fb));
    chk("m_take", 32'(pc_jmp_take), 32'(m_jt));
    chk("m_base", pc_stash_base, m_base);
    chk("m_mispredict", 32'(pc_mispredict), 32'(m_mis));
    chk("m_redirect", pc_redirect, m_redir);
    chk("m_count", 32'(stash_count), 32'(m_q.size()));
    chk("m_ready", 32'(push_ready), 32'(m_q.size() != 4));
    chk("m_underflow", 32'(stash_underflow), 32'(m_uf));
`ifdef BRANCH_STASH_STATS_EN
    chk("m_stat_res", stat_resolved, m_sres);
    chk("m_stat_mis", stat_mispredict, m_smis);
`endif
  endtask

  typedef struct {
    logic        push; logic [31:0] pc; logic pred;
    logic        res;  logic take; logic [31:0] tgt;
    logic        fb;   logic jt; logic [31:0] base;
    logic        mis;  logic [31:0] redir; int cnt; logic rdy; logic uf;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic push, input logic [31:0] pc, input logic pred,
                              input logic res, take, input logic [31:0] tgt,
                              input logic fb, jt, input logic [31:0] base,
                              input logic mis, input logic [31:0] redir,
                              input int cnt, input logic rdy, uf);
    vec_t v;
    v.push = push; v.pc = pc; v.pred = pred; v.res = res; v.take = take; v.tgt = tgt;
    v.fb = fb; v.jt = jt; v.base = base; v.mis = mis; v.redir = redir;
    v.cnt = cnt; v.rdy = rdy; v.uf = uf;
    return v;
  endfunction

  initial begin
    //            push pc     pd res tk tgt     fb jt base   mis redir  cnt rdy uf
    tv.push_back(mk(1, 'h100, 1, 0, 0, 0,     0, 0, 'h000, 0, 'h000, 1, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 1, 'h200, 1, 1, 'h100, 0, 'h000, 0, 1, 0));
    tv.push_back(mk(1, 'h104, 1, 0, 0, 0,     0, 1, 'h100, 0, 'h000, 1, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 0, 0,     1, 0, 'h104, 1, 'h108, 0, 1, 0));
    tv.push_back(mk(1, 'h500, 0, 0, 0, 0,     0, 0, 'h104, 0, 'h108, 0, 1, 0));
    tv.push_back(mk(1, 'h010, 0, 0, 0, 0,     0, 0, 'h104, 0, 'h108, 1, 1, 0));
    tv.push_back(mk(1, 'h020, 0, 0, 0, 0,     0, 0, 'h104, 0, 'h108, 2, 1, 0));
    tv.push_back(mk(1, 'h030, 0, 0, 0, 0,     0, 0, 'h104, 0, 'h108, 3, 1, 0));
    tv.push_back(mk(1, 'h040, 0, 1, 1, 'h080, 1, 1, 'h010, 1, 'h080, 0, 1, 0));
    tv.push_back(mk(1, 'h050, 0, 0, 0, 0,     0, 1, 'h010, 0, 'h080, 0, 1, 0));
    tv.push_back(mk(1, 'h060, 1, 0, 0, 0,     0, 1, 'h010, 0, 'h080, 1, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 1, 0,     1, 1, 'h060, 0, 'h080, 0, 1, 0));
    tv.push_back(mk(1, 'h200, 0, 0, 0, 0,     0, 1, 'h060, 0, 'h080, 1, 1, 0));
    tv.push_back(mk(1, 'h204, 1, 0, 0, 0,     0, 1, 'h060, 0, 'h080, 2, 1, 0));
    tv.push_back(mk(1, 'h208, 0, 0, 0, 0,     0, 1, 'h060, 0, 'h080, 3, 1, 0));
    tv.push_back(mk(1, 'h20C, 1, 0, 0, 0,     0, 1, 'h060, 0, 'h080, 4, 0, 0));
    tv.push_back(mk(1, 'h210, 0, 0, 0, 0,     0, 1, 'h060, 0, 'h080, 4, 0, 0));
    tv.push_back(mk(0, 0,     0, 1, 0, 0,     1, 0, 'h200, 0, 'h080, 3, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 1, 'h999, 1, 1, 'h204, 0, 'h080, 2, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 0, 0,     1, 0, 'h208, 0, 'h080, 1, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 1, 0,     1, 1, 'h20C, 0, 'h080, 0, 1, 0));
    tv.push_back(mk(0, 0,     0, 1, 1, 0,     0, 1, 'h20C, 0, 'h080, 0, 1, 1));
    tv.push_back(mk(0, 0,     0, 0, 0, 0,     0, 1, 'h20C, 0, 'h080, 0, 1, 1));

    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_count", 32'(stash_count), 0);
    chk("reset_ready", 32'(push_ready), 1);

    for (int i = 0; i < tv.size(); i++) begin
      cycle(0, tv[i].push, tv[i].pc, tv[i].pred, tv[i].res, tv[i].take, tv[i].tgt);
      chk($sformatf("v%0d_fb", i), 32'(pc_jmp_feedback), 32'(tv[i].fb));
      chk($sformatf("v%0d_take", i), 32'(pc_jmp_take), 32'(tv[i].jt));
      chk($sformatf("v%0d_base", i), pc_stash_base, tv[i].base);
      chk($sformatf("v%0d_mis", i), 32'(pc_mispredict), 32'(tv[i].mis));
      chk($sformatf("v%0d_redir", i), pc_redirect, tv[i].redir);
      chk($sformatf("v%0d_count", i), 32'(stash_count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(push_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_uf", i), 32'(stash_underflow), 32'(tv[i].uf));
    end

    // reset clears sticky underflow; reset during the flush shadow clears it too
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst_uf_clear", 32'(stash_underflow), 0);
    cycle(0, 1, 'h300, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_mis", 32'(pc_mispredict), 1);
    chk("pre_rst_redir", pc_redirect, 'h304);
    cycle(1, 1, 'h700, 0, 0, 0, 0);
    chk("rst_in_shadow_mis", 32'(pc_mispredict), 0);
    chk("rst_in_shadow_cnt", 32'(stash_count), 0);
    cycle(0, 1, 'h400, 1, 0, 0, 0);
    chk("post_shadow_push", 32'(stash_count), 1);
    cycle(0, 0, 0, 0, 1, 1, 'h900);
    chk("post_shadow_base", pc_stash_base, 'h400);

`ifdef BRANCH_STASH_STATS_EN
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 'hA00, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 'hB00);
    cycle(0, 1, 'hA04, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 'hA08, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("stat_resolved", stat_resolved, 3);
    chk("stat_mispredict", stat_mispredict, 1);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1),
            1'($urandom_range(0, 1)),
            $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
